// File: rtl/branch_predict_ctrl_if.sv
// Fetch-lookup / execute-resolution bus between the pipeline and the branch predictor.
interface branch_predict_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] if_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            ex_valid;
    logic            ex_stall;
    logic [2:0]      ex_br_type;
    logic            ex_br_taken;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     br_cnt;
    logic [31:0]     mis_cnt;

    modport master (
        output if_pc, ex_valid, ex_stall, ex_br_type, ex_br_taken, ex_pc, ex_target,
               ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, redirect, redirect_pc, br_cnt, mis_cnt
    );

    modport slave (
        input  if_pc, ex_valid, ex_stall, ex_br_type, ex_br_taken, ex_pc, ex_target,
               ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, redirect, redirect_pc, br_cnt, mis_cnt
    );
endinterface

// File: rtl/branch_predict_ctrl.sv
// Direct-mapped 2-bit-counter direction/target predictor with EX-stage redirect control
// and saturating branch/mispredict performance counters.
module branch_predict_ctrl #(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned XLEN  = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    branch_predict_ctrl_if.slave bus
);
    localparam int unsigned Entries = 2 ** IDX_W;

    typedef enum logic {StIdle, StRecover} state_e;

    state_e state_q, state_d;

    logic [Entries-1:0] valid_q, valid_d;
    logic [1:0]         ctr_q [Entries];
    logic [1:0]         ctr_d [Entries];
    logic [XLEN-1:0]    tgt_q [Entries];
    logic [XLEN-1:0]    tgt_d [Entries];
    logic [31:0]        br_cnt_q, br_cnt_d;
    logic [31:0]        mis_cnt_q, mis_cnt_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic             resolve, is_br, act_taken, mispred;
    logic [XLEN-1:0]  pc_inc, fix_pc;
    logic             unused_pc_bits;

    assign lk_idx = bus.if_pc[IDX_W+1:2];
    assign up_idx = bus.ex_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{bus.if_pc[1:0], bus.if_pc[XLEN-1:IDX_W+2], bus.ex_pc[1:0]};

    // Lookup reads registered state only, so a same-cycle update is seen next cycle.
    assign bus.pred_taken  = valid_q[lk_idx] & ctr_q[lk_idx][1];
    assign bus.pred_target = bus.pred_taken ? tgt_q[lk_idx] : '0;

    assign resolve   = bus.ex_valid & ~bus.ex_stall & (state_q == StIdle);
    assign is_br     = (bus.ex_br_type != 3'b000);
    assign act_taken = (bus.ex_br_type == 3'b111) | (is_br & bus.ex_br_taken);
    assign pc_inc    = bus.ex_pc + XLEN'(4);

    always_comb begin
        mispred = 1'b0;
        fix_pc  = pc_inc;
        if (!is_br) begin
            mispred = bus.ex_pred_taken;
        end else if (act_taken != bus.ex_pred_taken) begin
            mispred = 1'b1;
            fix_pc  = act_taken ? bus.ex_target : pc_inc;
        end else if (act_taken && (bus.ex_target != bus.ex_pred_target)) begin
            mispred = 1'b1;
            fix_pc  = bus.ex_target;
        end
    end

    assign bus.redirect    = resolve & mispred;
    assign bus.redirect_pc = bus.redirect ? fix_pc : '0;
    assign bus.br_cnt      = br_cnt_q;
    assign bus.mis_cnt     = mis_cnt_q;

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        ctr_d     = ctr_q;
        tgt_d     = tgt_q;
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;

        unique case (state_q)
            StIdle:    if (bus.redirect) state_d = StRecover;
            StRecover: state_d = StIdle;
            default:   state_d = StIdle;
        endcase

        if (resolve) begin
            if (!is_br) begin
                if (bus.ex_pred_taken) valid_d[up_idx] = 1'b0;
            end else if (valid_q[up_idx]) begin
                if (act_taken) begin
                    if (ctr_q[up_idx] != 2'b11) ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
                    tgt_d[up_idx] = bus.ex_target;
                end else if (ctr_q[up_idx] != 2'b00) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
                end
            end else if (act_taken) begin
                valid_d[up_idx] = 1'b1;
                ctr_d[up_idx]   = 2'b10;
                tgt_d[up_idx]   = bus.ex_target;
            end

            if (is_br && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + 32'd1;
            if (mispred && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            valid_q   <= '0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
            for (int i = 0; i < int'(Entries); i++) begin
                ctr_q[i] <= 2'b01;
                tgt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            ctr_q     <= ctr_d;
            tgt_q     <= tgt_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed-vector bench for branch_predict_ctrl with hand-computed expectations.
module tb_branch_predict_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    branch_predict_ctrl_if #(.XLEN(32)) bus ();

    branch_predict_ctrl #(
        .IDX_W(6),
        .XLEN (32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_ex(input logic v, input logic st, input logic [2:0] ty, input logic tk,
                            input logic [31:0] pc, input logic [31:0] tgt, input logic ptk,
                            input logic [31:0] ptgt);
        bus.ex_valid       = v;
        bus.ex_stall       = st;
        bus.ex_br_type     = ty;
        bus.ex_br_taken    = tk;
        bus.ex_pc          = pc;
        bus.ex_target      = tgt;
        bus.ex_pred_taken  = ptk;
        bus.ex_pred_target = ptgt;
        #1;
    endtask

    task automatic idle_ex();
        drive_ex(1'b0, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_redirect(input string tag, input logic r, input logic [31:0] pc);
        check_eq({tag, "_redirect"}, {31'd0, bus.redirect}, {31'd0, r});
        check_eq({tag, "_redirect_pc"}, bus.redirect_pc, pc);
    endtask

    task automatic check_pred(input string tag, input logic [31:0] pc, input logic t,
                              input logic [31:0] tgt);
        bus.if_pc = pc;
        #1;
        check_eq({tag, "_pred_taken"}, {31'd0, bus.pred_taken}, {31'd0, t});
        check_eq({tag, "_pred_target"}, bus.pred_target, tgt);
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] br, input logic [31:0] mis);
        check_eq({tag, "_br_cnt"}, bus.br_cnt, br);
        check_eq({tag, "_mis_cnt"}, bus.mis_cnt, mis);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        bus.if_pc = 32'h100;
        idle_ex();
        #12;
        check_pred("rst", 32'h100, 1'b0, 32'h0);
        check_redirect("rst", 1'b0, 32'h0);
        check_cnt("rst", 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // BEQ at 0x100 taken to 0x80, predicted not-taken: allocate, ctr=10.
        drive_ex(1'b1, 1'b0, 3'b001, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0);
        check_redirect("beq_alloc", 1'b1, 32'h80);
        check_pred("beq_alloc_pre", 32'h100, 1'b0, 32'h0);
        tick();
        check_pred("beq_alloc_post", 32'h100, 1'b1, 32'h80);
        check_cnt("beq_alloc", 32'd1, 32'd1);

        // RECOVER: a mismatching live instruction must be ignored.
        drive_ex(1'b1, 1'b0, 3'b001, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0);
        check_redirect("recover", 1'b0, 32'h0);
        tick();
        check_cnt("recover", 32'd1, 32'd1);

        // Two correct taken predictions: ctr 10 -> 11 -> 11.
        for (int i = 0; i < 2; i++) begin
            drive_ex(1'b1, 1'b0, 3'b001, 1'b1, 32'h100, 32'h80, 1'b1, 32'h80);
            check_redirect("beq_hit", 1'b0, 32'h0);
            tick();
        end
        check_cnt("beq_hit", 32'd3, 32'd1);

        // Not-taken: ctr 11 -> 10, still predicts taken.
        drive_ex(1'b1, 1'b0, 3'b001, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80);
        check_redirect("beq_nt1", 1'b1, 32'h104);
        tick();
        check_pred("beq_nt1", 32'h100, 1'b1, 32'h80);
        check_cnt("beq_nt1", 32'd4, 32'd2);
        idle_ex();
        tick();

        // Second not-taken: ctr 10 -> 01, now predicts not-taken.
        drive_ex(1'b1, 1'b0, 3'b001, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80);
        check_redirect("beq_nt2", 1'b1, 32'h104);
        tick();
        check_pred("beq_nt2", 32'h100, 1'b0, 32'h0);
        check_cnt("beq_nt2", 32'd5, 32'd3);
        idle_ex();
        tick();

        // Allocate 0x200, then a non-branch falsely predicted taken there.
        drive_ex(1'b1, 1'b0, 3'b010, 1'b1, 32'h200, 32'h300, 1'b0, 32'h0);
        check_redirect("bne_200", 1'b1, 32'h300);
        tick();
        idle_ex();
        check_pred("bne_200", 32'h200, 1'b1, 32'h300);
        tick();
        drive_ex(1'b1, 1'b0, 3'b000, 1'b0, 32'h200, 32'h0, 1'b1, 32'h300);
        check_redirect("nobr_200", 1'b1, 32'h204);
        tick();
        check_pred("nobr_200", 32'h200, 1'b0, 32'h0);
        check_cnt("nobr_200", 32'd6, 32'd5);
        idle_ex();
        tick();

        // Stalled mispredicting BNE: redirect only once the stall drops.
        for (int i = 0; i < 3; i++) begin
            drive_ex(1'b1, 1'b1, 3'b010, 1'b0, 32'h300, 32'h500, 1'b1, 32'h500);
            check_redirect("stall", 1'b0, 32'h0);
            tick();
        end
        check_cnt("stall", 32'd6, 32'd5);
        drive_ex(1'b1, 1'b0, 3'b010, 1'b0, 32'h300, 32'h500, 1'b1, 32'h500);
        check_redirect("unstall", 1'b1, 32'h304);
        tick();
        check_cnt("unstall", 32'd7, 32'd6);
        check_pred("unstall_noalloc", 32'h300, 1'b0, 32'h0);
        idle_ex();
        tick();

        // JAL at the top of the address space with a wrong predicted target.
        drive_ex(1'b1, 1'b0, 3'b111, 1'b0, 32'hFFFF_FFFC, 32'h20, 1'b1, 32'h10);
        check_redirect("jal", 1'b1, 32'h20);
        check_pred("jal_pre", 32'hFFFF_FFFC, 1'b0, 32'h0);
        force dut.mis_cnt_q = 32'hFFFF_FFFF;
        tick();
        release dut.mis_cnt_q;
        #1;
        check_cnt("jal_sat", 32'd8, 32'hFFFF_FFFF);
        check_pred("jal_post", 32'hFFFF_FFFC, 1'b1, 32'h20);
        idle_ex();
        tick();

        // Non-branch at 0xFFFFFFFC: PC+4 wraps to 0, mis_cnt stays saturated.
        drive_ex(1'b1, 1'b0, 3'b000, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h20);
        check_redirect("wrap", 1'b1, 32'h0);
        tick();
        check_cnt("wrap", 32'd8, 32'hFFFF_FFFF);
        check_pred("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
        idle_ex();
        tick();

        // Reset asserted mid-RECOVER clears table and counters immediately.
        drive_ex(1'b1, 1'b0, 3'b001, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0);
        check_redirect("pre_rst", 1'b1, 32'h80);
        tick();
        idle_ex();
        check_pred("pre_rst", 32'h100, 1'b1, 32'h80);
        rst_n = 1'b0;
        #1;
        check_pred("mid_rst", 32'h100, 1'b0, 32'h0);
        check_cnt("mid_rst", 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // After reset the FSM is IDLE again: a mispredict redirects at once.
        drive_ex(1'b1, 1'b0, 3'b001, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0);
        check_redirect("post_rst", 1'b1, 32'h80);
        tick();
        check_cnt("post_rst", 32'd1, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
